// File: rtl/pcileech_cfgmgmt_arb.sv
// ---------------------------------------------------------------------------
// pcileech_cfgmgmt_arb
//
// Shares the PCIe core configuration-management port between two requesters:
// A (host commands from the CFG FIFO path) and B (an internal config agent
// such as a DSN / shadow-register writer). Only one transaction is in flight
// at a time. Contention is resolved round-robin, and a transaction the core
// never completes is aborted after TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk_i, rst_i                single clock, asynchronous active-high reset
//   reqX_valid_i / reqX_ready_o request handshake (X = a, b); ready only in IDLE
//   reqX_wr_i                   1 = write, 0 = read
//   reqX_dwaddr_i               config DWORD address
//   reqX_data_i, reqX_be_i      write data and byte enables
//   rspX_valid_o                one-cycle completion pulse
//   rspX_data_o                 read data (0 for writes, FFFFFFFF on timeout)
//   rspX_timeout_o              qualifies rspX_valid_o: transaction aborted
//   cfg_mgmt_*_o / cfg_mgmt_*_i PCIe core configuration-management port
//   busy_o                      high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module pcileech_cfgmgmt_arb #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        reqa_valid_i,
    output logic        reqa_ready_o,
    input  logic        reqa_wr_i,
    input  logic [9:0]  reqa_dwaddr_i,
    input  logic [31:0] reqa_data_i,
    input  logic [3:0]  reqa_be_i,
    output logic        rspa_valid_o,
    output logic [31:0] rspa_data_o,
    output logic        rspa_timeout_o,

    input  logic        reqb_valid_i,
    output logic        reqb_ready_o,
    input  logic        reqb_wr_i,
    input  logic [9:0]  reqb_dwaddr_i,
    input  logic [31:0] reqb_data_i,
    input  logic [3:0]  reqb_be_i,
    output logic        rspb_valid_o,
    output logic [31:0] rspb_data_o,
    output logic        rspb_timeout_o,

    output logic        cfg_mgmt_rd_en_o,
    output logic        cfg_mgmt_wr_en_o,
    output logic [9:0]  cfg_mgmt_dwaddr_o,
    output logic [31:0] cfg_mgmt_di_o,
    output logic [3:0]  cfg_mgmt_byte_en_o,
    input  logic [31:0] cfg_mgmt_do_i,
    input  logic        cfg_mgmt_rd_wr_done_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic                lastGrantB_q, lastGrantB_d;
    logic                ownerB_q, ownerB_d;
    logic                wr_q, wr_d;
    logic                rdEn_q, rdEn_d;
    logic                wrEn_q, wrEn_d;
    logic [9:0]          addr_q, addr_d;
    logic [31:0]         di_q, di_d;
    logic [3:0]          be_q, be_d;
    logic [TO_WIDTH-1:0] toCnt_q, toCnt_d;
    logic [31:0]         rspData_q, rspData_d;
    logic                rspTimeout_q, rspTimeout_d;

    logic grantA, grantB, inIdle, accept, acceptWr;

    // Round-robin pick: B wins only when A is absent or A was served last.
    always_comb begin
        inIdle   = (state_q == IDLE);
        grantB   = reqb_valid_i && (!reqa_valid_i || !lastGrantB_q);
        grantA   = reqa_valid_i && !grantB;
        accept   = inIdle && (grantA || grantB);
        acceptWr = grantB ? reqb_wr_i : reqa_wr_i;
    end

    assign reqa_ready_o = inIdle && grantA;
    assign reqb_ready_o = inIdle && grantB;

    // Next-state and datapath: the core-facing signals are all registered so
    // the enable rises one cycle after acceptance with address/data stable.
    always_comb begin
        state_d      = state_q;
        lastGrantB_d = lastGrantB_q;
        ownerB_d     = ownerB_q;
        wr_d         = wr_q;
        rdEn_d       = rdEn_q;
        wrEn_d       = wrEn_q;
        addr_d       = addr_q;
        di_d         = di_q;
        be_d         = be_q;
        toCnt_d      = toCnt_q;
        rspData_d    = rspData_q;
        rspTimeout_d = rspTimeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ownerB_d     = grantB;
                    lastGrantB_d = grantB;
                    wr_d         = acceptWr;
                    wrEn_d       = acceptWr;
                    rdEn_d       = !acceptWr;
                    addr_d       = grantB ? reqb_dwaddr_i : reqa_dwaddr_i;
                    // Reads present zero data and byte enables to the core.
                    di_d         = acceptWr ? (grantB ? reqb_data_i : reqa_data_i) : 32'h0;
                    be_d         = acceptWr ? (grantB ? reqb_be_i : reqa_be_i) : 4'h0;
                    toCnt_d      = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // Done is tested first so it wins over a coincident timeout.
                if (cfg_mgmt_rd_wr_done_i) begin
                    rdEn_d       = 1'b0;
                    wrEn_d       = 1'b0;
                    rspData_d    = wr_q ? 32'h0 : cfg_mgmt_do_i;
                    rspTimeout_d = 1'b0;
                    state_d      = RESP;
                end else if (toCnt_q == TO_LIMIT) begin
                    rdEn_d       = 1'b0;
                    wrEn_d       = 1'b0;
                    rspData_d    = 32'hFFFF_FFFF;
                    rspTimeout_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            RESP: begin
                addr_d  = '0;
                di_d    = '0;
                be_d    = '0;
                state_d = GAP;
            end
            GAP: begin
                // Late done from an aborted access is simply not looked at.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops the core enables immediately and leaves
    // B as last grant so A wins the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lastGrantB_q <= 1'b1;
            ownerB_q     <= 1'b0;
            wr_q         <= 1'b0;
            rdEn_q       <= 1'b0;
            wrEn_q       <= 1'b0;
            addr_q       <= '0;
            di_q         <= '0;
            be_q         <= '0;
            toCnt_q      <= '0;
            rspData_q    <= '0;
            rspTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrantB_q <= lastGrantB_d;
            ownerB_q     <= ownerB_d;
            wr_q         <= wr_d;
            rdEn_q       <= rdEn_d;
            wrEn_q       <= wrEn_d;
            addr_q       <= addr_d;
            di_q         <= di_d;
            be_q         <= be_d;
            toCnt_q      <= toCnt_d;
            rspData_q    <= rspData_d;
            rspTimeout_q <= rspTimeout_d;
        end
    end

    assign cfg_mgmt_rd_en_o   = rdEn_q;
    assign cfg_mgmt_wr_en_o   = wrEn_q;
    assign cfg_mgmt_dwaddr_o  = addr_q;
    assign cfg_mgmt_di_o      = di_q;
    assign cfg_mgmt_byte_en_o = be_q;

    // Response fields are forced to zero outside the single RESP cycle.
    assign rspa_valid_o   = (state_q == RESP) && !ownerB_q;
    assign rspb_valid_o   = (state_q == RESP) && ownerB_q;
    assign rspa_data_o    = rspa_valid_o ? rspData_q : 32'h0;
    assign rspb_data_o    = rspb_valid_o ? rspData_q : 32'h0;
    assign rspa_timeout_o = rspa_valid_o && rspTimeout_q;
    assign rspb_timeout_o = rspb_valid_o && rspTimeout_q;

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_pcileech_cfgmgmt_arb.sv
// ---------------------------------------------------------------------------
// tb_pcileech_cfgmgmt_arb
//
// Self-checking bench for the config-management arbiter. Requests push their
// expected completion into a per-requester queue on acceptance; a monitor
// pops and compares when the arbiter pulses a response. A small core model
// returns done a programmable number of cycles after an enable rises.
// ---------------------------------------------------------------------------
module tb_pcileech_cfgmgmt_arb;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqa_valid, reqa_ready, reqa_wr;
    logic [9:0]  reqa_dwaddr;
    logic [31:0] reqa_data;
    logic [3:0]  reqa_be;
    logic        rspa_valid, rspa_timeout;
    logic [31:0] rspa_data;
    logic        reqb_valid, reqb_ready, reqb_wr;
    logic [9:0]  reqb_dwaddr;
    logic [31:0] reqb_data;
    logic [3:0]  reqb_be;
    logic        rspb_valid, rspb_timeout;
    logic [31:0] rspb_data;
    logic        rdEn, wrEn;
    logic [9:0]  cfgAddr;
    logic [31:0] cfgDi, cfgDo;
    logic [3:0]  cfgBe;
    logic        cfgDone;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        timeout;
    } rsp_t;

    rsp_t qA[$];
    rsp_t qB[$];
    int   grantWho[$];
    int   grantCyc[$];

    int checks = 0;
    int failures = 0;
    int violations = 0;
    int cycle = 0;
    int rspaCount = 0;
    int rspbCount = 0;

    int          coreDelay = 0;
    logic [31:0] coreData = 32'h0;
    logic        forceDone = 1'b0;
    int          enCnt = 0;

    int          rdRun = 0, wrRun = 0, lastRdLen = 0, lastWrLen = 0;
    logic [9:0]  lastAddr = '0;
    logic [31:0] lastDi = '0;
    logic [3:0]  lastBe = '0;

    pcileech_cfgmgmt_arb #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(10)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .reqa_valid_i          (reqa_valid),
        .reqa_ready_o          (reqa_ready),
        .reqa_wr_i             (reqa_wr),
        .reqa_dwaddr_i         (reqa_dwaddr),
        .reqa_data_i           (reqa_data),
        .reqa_be_i             (reqa_be),
        .rspa_valid_o          (rspa_valid),
        .rspa_data_o           (rspa_data),
        .rspa_timeout_o        (rspa_timeout),
        .reqb_valid_i          (reqb_valid),
        .reqb_ready_o          (reqb_ready),
        .reqb_wr_i             (reqb_wr),
        .reqb_dwaddr_i         (reqb_dwaddr),
        .reqb_data_i           (reqb_data),
        .reqb_be_i             (reqb_be),
        .rspb_valid_o          (rspb_valid),
        .rspb_data_o           (rspb_data),
        .rspb_timeout_o        (rspb_timeout),
        .cfg_mgmt_rd_en_o      (rdEn),
        .cfg_mgmt_wr_en_o      (wrEn),
        .cfg_mgmt_dwaddr_o     (cfgAddr),
        .cfg_mgmt_di_o         (cfgDi),
        .cfg_mgmt_byte_en_o    (cfgBe),
        .cfg_mgmt_do_i         (cfgDo),
        .cfg_mgmt_rd_wr_done_i (cfgDone),
        .busy_o                (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Core model: done rises coreDelay cycles into an enable (0 = never).
    initial begin
        cfgDone = 1'b0;
        cfgDo   = 32'h0;
        forever begin
            @(negedge clk);
            if (rdEn || wrEn) enCnt++;
            else enCnt = 0;
            cfgDo   = coreData;
            cfgDone = forceDone || (coreDelay > 0 && enCnt == coreDelay);
        end
    end

    // Monitor: grants, enable pulse lengths, stability, and responses.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reqa_valid && reqa_ready) begin grantWho.push_back(0); grantCyc.push_back(cycle); end
            if (reqb_valid && reqb_ready) begin grantWho.push_back(1); grantCyc.push_back(cycle); end
            if (reqa_ready && reqb_ready) violations++;
            if (rdEn && wrEn) violations++;
            if (rdEn || wrEn) begin
                if (rdRun == 0 && wrRun == 0) begin
                    lastAddr = cfgAddr; lastDi = cfgDi; lastBe = cfgBe;
                end else if (lastAddr !== cfgAddr || lastDi !== cfgDi || lastBe !== cfgBe) begin
                    violations++;
                end
            end
            if (rdEn) rdRun++;
            else if (rdRun > 0) begin lastRdLen = rdRun; rdRun = 0; end
            if (wrEn) wrRun++;
            else if (wrRun > 0) begin lastWrLen = wrRun; wrRun = 0; end
            if (rspa_valid && rspb_valid) violations++;
            if (!rspa_valid && (rspa_data != 0 || rspa_timeout)) violations++;
            if (!rspb_valid && (rspb_data != 0 || rspb_timeout)) violations++;
            if (rspa_valid) begin
                rspaCount++;
                if (qA.size() == 0) checkOutput("rspaUnexpected", 32'd1, 32'd0);
                else begin
                    e = qA.pop_front();
                    checkOutput("rspaData", rspa_data, e.data);
                    checkOutput("rspaTimeout", 32'(rspa_timeout), 32'(e.timeout));
                end
            end
            if (rspb_valid) begin
                rspbCount++;
                if (qB.size() == 0) checkOutput("rspbUnexpected", 32'd1, 32'd0);
                else begin
                    e = qB.pop_front();
                    checkOutput("rspbData", rspb_data, e.data);
                    checkOutput("rspbTimeout", 32'(rspb_timeout), 32'(e.timeout));
                end
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, queue the expected
    // completion, then scramble the inputs to prove they are not re-sampled.
    task automatic applyStimulus(input bit toB, input logic wr, input logic [9:0] addr,
                                 input logic [31:0] data, input logic [3:0] be,
                                 input logic [31:0] expData, input logic expTo);
        bit   taken = 0;
        rsp_t e;
        @(posedge clk); #1;
        if (!toB) begin
            reqa_valid = 1'b1; reqa_wr = wr; reqa_dwaddr = addr; reqa_data = data; reqa_be = be;
        end else begin
            reqb_valid = 1'b1; reqb_wr = wr; reqb_dwaddr = addr; reqb_data = data; reqb_be = be;
        end
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            if (toB ? reqb_ready : reqa_ready) taken = 1;
        end
        e.data = expData;
        e.timeout = expTo;
        if (taken) begin
            if (toB) qB.push_back(e);
            else qA.push_back(e);
        end else begin
            checkOutput(toB ? "acceptB" : "acceptA", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        if (!toB) begin
            reqa_valid = 1'b0; reqa_wr = 1'($urandom); reqa_dwaddr = 10'($urandom);
            reqa_data = $urandom; reqa_be = 4'($urandom);
        end else begin
            reqb_valid = 1'b0; reqb_wr = 1'($urandom); reqb_dwaddr = 10'($urandom);
            reqb_data = $urandom; reqb_be = 4'($urandom);
        end
    endtask

    task automatic waitQuiet();
        bit quiet = 0;
        for (int i = 0; i < 400 && !quiet; i++) begin
            @(negedge clk);
            if (qA.size() == 0 && qB.size() == 0 && !busy) quiet = 1;
        end
        checkOutput("quietBound", 32'(quiet), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int aCnt, bCnt;
        rst = 1'b1;
        reqa_valid = 0; reqa_wr = 0; reqa_dwaddr = 0; reqa_data = 0; reqa_be = 0;
        reqb_valid = 0; reqb_wr = 0; reqb_dwaddr = 0; reqb_data = 0; reqb_be = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstRdEn", 32'(rdEn), 32'd0);
        checkOutput("rstWrEn", 32'(wrEn), 32'd0);
        checkOutput("rstAddr", 32'(cfgAddr), 32'd0);
        checkOutput("rstRspValid", 32'({rspa_valid, rspb_valid}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single read from A");
        coreDelay = 3; coreData = 32'h0010_0406;
        aCnt = rspaCount; bCnt = rspbCount;
        applyStimulus(0, 1'b0, 10'h004, 32'h1234_5678, 4'hF, 32'h0010_0406, 1'b0);
        waitQuiet();
        checkOutput("readRdLen", 32'(lastRdLen), 32'd3);
        checkOutput("readAddr", 32'(lastAddr), 32'h004);
        checkOutput("readDi", lastDi, 32'h0);
        checkOutput("readBe", 32'(lastBe), 32'h0);
        checkOutput("readRspaCount", 32'(rspaCount - aCnt), 32'd1);
        checkOutput("readRspbCount", 32'(rspbCount - bCnt), 32'd0);

        $display("[TB] single write from B");
        coreDelay = 1; coreData = 32'hDEAD_BEEF;
        aCnt = rspaCount; bCnt = rspbCount;
        applyStimulus(1, 1'b1, 10'h001, 32'h0000_0006, 4'h3, 32'h0, 1'b0);
        waitQuiet();
        checkOutput("writeWrLen", 32'(lastWrLen), 32'd1);
        checkOutput("writeAddr", 32'(lastAddr), 32'h001);
        checkOutput("writeDi", lastDi, 32'h6);
        checkOutput("writeBe", 32'(lastBe), 32'h3);
        checkOutput("writeRspbCount", 32'(rspbCount - bCnt), 32'd1);
        checkOutput("writeRspaCount", 32'(rspaCount - aCnt), 32'd0);

        $display("[TB] contention round-robin");
        coreDelay = 1; coreData = 32'hCAFE_0001;
        grantWho.delete(); grantCyc.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    applyStimulus(0, 1'b0, 10'(10'h010 + i), 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);
            end
            begin
                for (int j = 0; j < 3; j++)
                    applyStimulus(1, 1'b1, 10'(10'h020 + j), 32'(j + 100), 4'hF, 32'h0, 1'b0);
            end
        join
        waitQuiet();
        checkOutput("grantCount", 32'(grantWho.size()), 32'd6);
        for (int k = 0; k < grantWho.size(); k++) begin
            checkOutput("grantOrder", 32'(grantWho[k]), 32'(k % 2));
            if (k > 0) checkOutput("grantSpacing", 32'(grantCyc[k] - grantCyc[k-1]), 32'd4);
        end

        $display("[TB] timeout on read from A");
        coreDelay = 0;
        applyStimulus(0, 1'b0, 10'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1);
        waitQuiet();
        checkOutput("timeoutRdLen", 32'(lastRdLen), 32'(TO));
        aCnt = rspaCount;
        forceDone = 1'b1;
        @(negedge clk);
        @(negedge clk);
        forceDone = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("lateDoneBusy", 32'(busy), 32'd0);
        checkOutput("lateDoneRsp", 32'(rspaCount - aCnt), 32'd0);

        $display("[TB] done coincides with timeout limit");
        coreDelay = TO; coreData = 32'h0BAD_F00D;
        applyStimulus(0, 1'b0, 10'h00D, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
        waitQuiet();
        checkOutput("coincideRdLen", 32'(lastRdLen), 32'(TO));

        $display("[TB] reset during read issue");
        coreDelay = 0;
        applyStimulus(0, 1'b0, 10'h00E, 32'h0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("preRstRdEn", 32'(rdEn), 32'd1);
        @(negedge clk);
        aCnt = rspaCount;
        rst = 1'b1;
        #1;
        checkOutput("midRstRdEn", 32'(rdEn), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        qA.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        coreDelay = 2; coreData = 32'h1357_2468;
        grantWho.delete(); grantCyc.delete();
        fork
            applyStimulus(0, 1'b0, 10'h00F, 32'h0, 4'h0, 32'h1357_2468, 1'b0);
            applyStimulus(1, 1'b1, 10'h030, 32'h55, 4'h1, 32'h0, 1'b0);
        join
        waitQuiet();
        checkOutput("postRstFirstGrant", 32'(grantWho.size() > 0 ? grantWho[0] : 99), 32'd0);
        checkOutput("postRstRspaCount", 32'(rspaCount - aCnt), 32'd1);

        checkOutput("protocolViolations", 32'(violations), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
